cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step/breakpoint sequencer for the GB CPU core. Drives a single-cycle clock
//  enable (cpu_ce) into the CPU from a free-running prescaler, and gates it by a
//  run-state FSM fed by host/button request pulses. The CPU's debug outputs
//  (pc, instruction_retired, halted) feed back so the block can single-step,
//  stop on a PC breakpoint, freeze on HALT, and count retired instructions.
// PARAMETERS
//  DIV_W   16  prescaler width; one cpu_ce opportunity every 2**DIV_W clk cycles
//  CNT_W   32  width of retired-instruction counter
// PORTS
//  clk                      in   1      system clock
//  rst_n                    in   1      asynchronous reset, active low
//  run_req                  in   1      1-cycle pulse: free-run
//  stop_req                 in   1      1-cycle pulse: pause
//  step_req                 in   1      1-cycle pulse: execute exactly one instruction
//  bp_valid                 in   1      breakpoint armed
//  bp_addr                  in   16     breakpoint PC
//  dbg_pc                   in   16     CPU program counter
//  dbg_instruction_retired  in   1      CPU retire strobe
//  dbg_halted               in   1      CPU in HALT (level)
//  cpu_ce                   out  1      CPU clock enable, 1 clk wide
//  state                    out  3      FSM state encoding (below)
//  retire_cnt               out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Reset: prescaler=0, state=PAUSED, cpu_ce=0, retire_cnt=0, skip_bp=0; rst_n
//   asserted mid-instruction freezes the CPU immediately (cpu_ce forced 0).
//  Prescaler: free-running DIV_W-bit up counter, wraps; never cleared by FSM.
//   tick = (prescaler == all ones).
//  cpu_ce = tick & (state==RUN | state==STEP); combinational from registered state.
//  ce_q: registered copy of cpu_ce. ret_seen = ce_q & dbg_instruction_retired
//   (retire is observed in the cycle after the enabling edge).
//  retire_cnt += 1 on every ret_seen, any state; wraps at 2**CNT_W.
//  States: PAUSED=0, RUN=1, STEP=2, HALTED=3, BREAK=4.
//  Request priority in all states: stop_req > run_req > step_req.
//  PAUSED: run_req->RUN; step_req->STEP.
//  RUN:    stop_req->PAUSED; else dbg_halted->HALTED; else ret_seen & bp_hit->BREAK.
//  STEP:   stop_req->PAUSED (abort, CPU frozen mid-instruction);
//          else dbg_halted->HALTED; else ret_seen->PAUSED. run_req/step_req ignored.
//  BREAK:  stop_req->PAUSED; run_req->RUN, set skip_bp; step_req->STEP, set skip_bp.
//  HALTED: sticky; cpu_ce=0; all requests ignored; left only via rst_n.
//  bp_hit = bp_valid & (dbg_pc==bp_addr) & ~skip_bp, evaluated on ret_seen (PC of
//   next instruction). skip_bp clears on the first ret_seen after it is set.
//  First cpu_ce after entering RUN/STEP occurs at next tick; no extra latency.
//  Simultaneous stop_req and ret_seen: state->PAUSED, retire still counted.
// CONFIGURATION
//  BREAKPOINT_EN defined: breakpoint logic as above.
//  BREAKPOINT_EN undefined: bp_valid/bp_addr ignored, bp_hit=0, BREAK unreachable,
//   skip_bp removed; ports remain for interface stability.
// TESTING (DIV_W=2: tick every 4 clk; CPU model retires 1 instr per cpu_ce)
//  1 reset, idle 20 clk -> state=0, cpu_ce never high, retire_cnt=0.
//  2 PAUSED, step_req -> exactly one cpu_ce pulse, retire_cnt=1, state back to 0.
//  3 run_req, 40 clk -> cpu_ce every 4th clk, retire_cnt=10; stop_req -> state=0, no ce.
//  4 BREAKPOINT_EN, bp_addr=0x0150, model pc 0x0100+n -> state=4 once pc=0x0150;
//    run_req -> resumes past 0x0150, no re-break on that retire.
//  5 RUN, dbg_halted=1 -> state=3; run_req/step_req ignored; rst_n low -> state=0.
//  6 stop_req and run_req same cycle in PAUSED -> state stays 0; rst_n pulse mid-STEP
//    -> cpu_ce=0 same cycle, retire_cnt=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint sequencer gating the GB CPU clock enable.
// Optional feature macro: BREAKPOINT_EN (PC breakpoint with skip-after-resume).
module cpu_run_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic             step_req,
  input  logic             bp_valid,
  input  logic [15:0]      bp_addr,
  input  logic [15:0]      dbg_pc,
  input  logic             dbg_instruction_retired,
  input  logic             dbg_halted,
  output logic             cpu_ce,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [2:0] ST_PAUSED = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_HALTED = 3'd3;
`ifdef BREAKPOINT_EN
  localparam logic [2:0] ST_BREAK  = 3'd4;
`endif

  logic [DIV_W-1:0] presc_r;
  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic             ce_q_r;
  logic [CNT_W-1:0] retire_cnt_r;
  logic             tick_s;
  logic             ret_seen_s;
  logic             bp_hit_s;

  assign tick_s     = (presc_r == {DIV_W{1'b1}});
  assign cpu_ce     = tick_s & ((state_r == ST_RUN) | (state_r == ST_STEP));
  // The CPU reports retirement one cycle after the edge we enabled.
  assign ret_seen_s = ce_q_r & dbg_instruction_retired;
  assign state      = state_r;
  assign retire_cnt = retire_cnt_r;

`ifdef BREAKPOINT_EN
  logic skip_bp_r;
  logic skip_set_s;

  assign bp_hit_s   = bp_valid & (dbg_pc == bp_addr) & ~skip_bp_r;
  assign skip_set_s = (state_r == ST_BREAK) & ~stop_req & (run_req | step_req);

  // Resuming from a break ignores the breakpoint for exactly one retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_bp_r <= 1'b0;
    end else if (skip_set_s) begin
      skip_bp_r <= 1'b1;
    end else if (ret_seen_s) begin
      skip_bp_r <= 1'b0;
    end else begin
      skip_bp_r <= skip_bp_r;
    end
  end
`else
  logic unused_bp_s;

  assign unused_bp_s = ^{bp_valid, bp_addr, dbg_pc};
  assign bp_hit_s    = 1'b0;
`endif

  // Free-running prescaler, enable pipeline and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r      <= {DIV_W{1'b0}};
      ce_q_r       <= 1'b0;
      retire_cnt_r <= {CNT_W{1'b0}};
    end else begin
      presc_r <= presc_r + DIV_W'(1);
      ce_q_r  <= cpu_ce;
      if (ret_seen_s) begin
        retire_cnt_r <= retire_cnt_r + CNT_W'(1);
      end else begin
        retire_cnt_r <= retire_cnt_r;
      end
    end
  end

  // Next-state decode; stop outranks run, run outranks step.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_PAUSED: begin
        if (stop_req) begin
          state_nxt_s = ST_PAUSED;
        end else if (run_req) begin
          state_nxt_s = ST_RUN;
        end else if (step_req) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_nxt_s = ST_PAUSED;
        end else if (dbg_halted) begin
          state_nxt_s = ST_HALTED;
`ifdef BREAKPOINT_EN
        end else if (ret_seen_s & bp_hit_s) begin
          state_nxt_s = ST_BREAK;
`endif
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STEP: begin
        if (stop_req) begin
          state_nxt_s = ST_PAUSED;
        end else if (dbg_halted) begin
          state_nxt_s = ST_HALTED;
        end else if (ret_seen_s) begin
          state_nxt_s = ST_PAUSED;
        end else begin
          state_nxt_s = ST_STEP;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
`ifdef BREAKPOINT_EN
      ST_BREAK: begin
        if (stop_req) begin
          state_nxt_s = ST_PAUSED;
        end else if (run_req) begin
          state_nxt_s = ST_RUN;
        end else if (step_req) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_PAUSED;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_PAUSED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifndef BREAKPOINT_EN
  logic unused_hit_s;
  assign unused_hit_s = bp_hit_s;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV_W=2 and a CPU model retiring one
// instruction per cpu_ce (pc starts at 0x0100 and advances by one per retire).
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run_req;
  logic        stop_req;
  logic        step_req;
  logic        bp_valid;
  logic [15:0] bp_addr;
  logic [15:0] model_pc;
  logic        model_ret;
  logic        dbg_halted;
  logic        cpu_ce;
  logic [2:0]  state;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int ce_count = 0;
  int ce_before;

  cpu_run_ctrl #(.DIV_W(2), .CNT_W(32)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .run_req                 (run_req),
    .stop_req                (stop_req),
    .step_req                (step_req),
    .bp_valid                (bp_valid),
    .bp_addr                 (bp_addr),
    .dbg_pc                  (model_pc),
    .dbg_instruction_retired (model_ret),
    .dbg_halted              (dbg_halted),
    .cpu_ce                  (cpu_ce),
    .state                   (state),
    .retire_cnt              (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU model: retire strobe and next-instruction pc one cycle after cpu_ce.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_pc  <= 16'h0100;
      model_ret <= 1'b0;
    end else begin
      model_ret <= cpu_ce;
      if (cpu_ce) model_pc <= model_pc + 16'd1;
    end
  end

  always @(negedge clk) if (cpu_ce === 1'b1) ce_count = ce_count + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int max_cyc);
    for (int i = 0; i < max_cyc && state !== exp; i++) step();
    chk(tag, {29'd0, state}, {29'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; run_req = 1'b0; stop_req = 1'b0; step_req = 1'b0;
    bp_valid = 1'b0; bp_addr = 16'h0000; dbg_halted = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (20) step();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_no_ce", ce_count, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);

    // 2: single step
    ce_before = ce_count;
    step_req = 1'b1; step(); step_req = 1'b0;
    chk("step_state", {29'd0, state}, 32'd2);
    repeat (11) step();
    chk("step_ce_once", ce_count - ce_before, 32'd1);
    chk("step_retire", retire_cnt, 32'd1);
    chk("step_back_paused", {29'd0, state}, 32'd0);

    // 3: free run for 40 cycles then stop
    ce_before = ce_count;
    run_req = 1'b1; step(); run_req = 1'b0;
    chk("run_state", {29'd0, state}, 32'd1);
    repeat (39) step();
    stop_req = 1'b1; step(); stop_req = 1'b0;
    chk("run_ce_count", ce_count - ce_before, 32'd10);
    chk("stop_state", {29'd0, state}, 32'd0);
    ce_before = ce_count;
    repeat (6) step();
    chk("stop_no_ce", ce_count - ce_before, 32'd0);
    chk("run_retire", retire_cnt, 32'd11);

`ifdef BREAKPOINT_EN
    // 4: breakpoint at 0x0150, resume with skip, re-arm at 0x0158
    bp_valid = 1'b1; bp_addr = 16'h0150;
    run_req = 1'b1; step(); run_req = 1'b0;
    wait_state("bp_break", 3'd4, 400);
    chk("bp_retire", retire_cnt, 32'd80);
    ce_before = ce_count;
    repeat (10) step();
    chk("bp_held", {29'd0, state}, 32'd4);
    chk("bp_no_ce", ce_count - ce_before, 32'd0);
    bp_addr = 16'h0151;
    run_req = 1'b1; step(); run_req = 1'b0;
    repeat (12) step();
    chk("bp_skip_run", {29'd0, state}, 32'd1);
    bp_addr = 16'h0158;
    wait_state("bp_rearm", 3'd4, 60);
    chk("bp_rearm_retire", retire_cnt, 32'd88);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    chk("bp_stop", {29'd0, state}, 32'd0);
`else
    // 4: breakpoint inputs ignored without the feature
    bp_valid = 1'b1; bp_addr = 16'h0110;
    run_req = 1'b1; step(); run_req = 1'b0;
    repeat (39) step();
    chk("nobp_still_run", {29'd0, state}, 32'd1);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    repeat (6) step();
    chk("nobp_retire", retire_cnt, 32'd21);
    chk("nobp_stop", {29'd0, state}, 32'd0);
`endif
    bp_valid = 1'b0;

    // 5: HALT is sticky until reset
    run_req = 1'b1; step(); run_req = 1'b0;
    repeat (8) step();
    dbg_halted = 1'b1;
    repeat (2) step();
    chk("halt_state", {29'd0, state}, 32'd3);
    ce_before = ce_count;
    run_req = 1'b1; step(); run_req = 1'b0;
    step_req = 1'b1; step(); step_req = 1'b0;
    stop_req = 1'b1; step(); stop_req = 1'b0;
    repeat (8) step();
    chk("halt_sticky", {29'd0, state}, 32'd3);
    chk("halt_no_ce", ce_count - ce_before, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_state", {29'd0, state}, 32'd0);
    chk("halt_rst_retire", retire_cnt, 32'd0);
    dbg_halted = 1'b0;
    step();
    rst_n = 1'b1;

    // 6: stop wins over run; reset during a step freezes the CPU at once
    step_req = 1'b1; step(); step_req = 1'b0;
    repeat (11) step();
    chk("s6_step_retire", retire_cnt, 32'd1);
    ce_before = ce_count;
    stop_req = 1'b1; run_req = 1'b1; step(); stop_req = 1'b0; run_req = 1'b0;
    chk("stop_beats_run", {29'd0, state}, 32'd0);
    repeat (8) step();
    chk("stop_run_no_ce", ce_count - ce_before, 32'd0);
    step_req = 1'b1; step(); step_req = 1'b0;
    for (int i = 0; i < 8 && cpu_ce !== 1'b1; i++) step();
    chk("s6_ce_seen", {31'd0, cpu_ce}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("s6_rst_retire", retire_cnt, 32'd0);
    chk("s6_rst_state", {29'd0, state}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
